// File: rtl/sha256_block_sched_if.sv
// Block-stream handshake, datapath strobes and digest handshake between the
// SHA-256 round controller and its padder / datapath / consumer neighbours.
interface sha256_block_sched_if #(
  parameter int CNT_W = 16
);
  logic             blk_valid;
  logic             blk_first;
  logic             blk_last;
  logic             blk_ready;
  logic             init_h;
  logic             load_ws;
  logic             round_en;
  logic [5:0]       round_idx;
  logic [31:0]      k_out;
  logic             accum;
  logic             digest_valid;
  logic             digest_ack;
  logic             busy;
  logic [CNT_W-1:0] blk_count;

  // Environment side: padder, datapath and digest consumer.
  modport master (
    output blk_valid, blk_first, blk_last, digest_ack,
    input  blk_ready, init_h, load_ws, round_en, round_idx, k_out,
    input  accum, digest_valid, busy, blk_count
  );

  // Controller side.
  modport slave (
    input  blk_valid, blk_first, blk_last, digest_ack,
    output blk_ready, init_h, load_ws, round_en, round_idx, k_out,
    output accum, digest_valid, busy, blk_count
  );
endinterface

// File: rtl/sha256_block_sched.sv
// Control sequencer for a SHA-256 compression datapath: IV init, working-set
// load, NUM_ROUNDS rounds with K_t, H accumulate, then a held digest-valid.
module sha256_block_sched #(
  parameter int CNT_W      = 16,
  parameter int NUM_ROUNDS = 64
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 en,
  sha256_block_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t           state_reg, state_next;
  logic [5:0]       rnd_reg, rnd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             msg_active_reg, msg_active_next;
  logic             last_reg, last_next;

  logic             ready_c;
  logic             init_c;
  logic             load_c;
  logic             round_c;
  logic             accum_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      rnd_reg        <= '0;
      cnt_reg        <= '0;
      msg_active_reg <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rnd_reg        <= rnd_next;
      cnt_reg        <= cnt_next;
      msg_active_reg <= msg_active_next;
      last_reg       <= last_next;
    end
  end

  // With en low nothing below fires, so every register simply holds.
  always_comb begin
    state_next      = state_reg;
    rnd_next        = rnd_reg;
    cnt_next        = cnt_reg;
    msg_active_next = msg_active_reg;
    last_next       = last_reg;
    ready_c         = 1'b0;
    init_c          = 1'b0;
    load_c          = 1'b0;
    round_c         = 1'b0;
    accum_c         = 1'b0;
    if (en) begin
      case (state_reg)
        S_IDLE: begin
          ready_c = 1'b1;
          if (bus.blk_valid) begin
            // A stray non-first block opens a fresh message; a first block
            // mid-message abandons the open one.
            if (bus.blk_first || !msg_active_reg) begin
              init_c   = 1'b1;
              cnt_next = '0;
            end
            last_next       = bus.blk_last;
            msg_active_next = 1'b1;
            state_next      = S_LOAD;
          end
        end
        S_LOAD: begin
          load_c     = 1'b1;
          rnd_next   = '0;
          state_next = S_ROUND;
        end
        S_ROUND: begin
          round_c  = 1'b1;
          rnd_next = rnd_reg + 6'd1;
          if (rnd_reg == LAST_RND) begin
            state_next = S_ACCUM;
          end
        end
        S_ACCUM: begin
          accum_c = 1'b1;
          if (cnt_reg != '1) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          if (last_reg) begin
            msg_active_next = 1'b0;
            state_next      = S_DONE;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_DONE: begin
          if (bus.digest_ack) begin
            cnt_next   = '0;
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Every output is forced low while reset is asserted, even before the edge.
  assign bus.blk_ready    = ready_c & reset;
  assign bus.init_h       = init_c & reset;
  assign bus.load_ws      = load_c & reset;
  assign bus.round_en     = round_c & reset;
  assign bus.accum        = accum_c & reset;
  assign bus.round_idx    = (reset && state_reg == S_ROUND) ? rnd_reg : 6'd0;
  assign bus.k_out        = (reset && state_reg == S_ROUND) ? K_ROM[rnd_reg] : 32'd0;
  assign bus.digest_valid = reset && (state_reg == S_DONE);
  assign bus.busy         = reset && (state_reg != S_IDLE);
  assign bus.blk_count    = reset ? cnt_reg : '0;

endmodule

// File: tb/tb_sha256_block_sched.sv
// Bench for sha256_block_sched: a behavioural SHA-256 datapath follows the
// strobes and a scoreboard of expected digests/counts is checked on digest_valid.
module tb_sha256_block_sched;
  localparam int CNT_W = 16;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2B =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_2B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic clk = 1'b0;
  logic reset;
  logic en;
  always #5 clk = ~clk;

  sha256_block_sched_if #(.CNT_W(CNT_W)) bus ();
  sha256_block_sched #(.CNT_W(CNT_W), .NUM_ROUNDS(64)) dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural datapath, clocked on the falling edge so the strobes are settled.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] t1f(input logic [31:0] h, e, f, g, k, w);
    return h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
  endfunction
  function automatic logic [31:0] t2f(input logic [31:0] a, b, c);
    return (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
  endfunction
  function automatic logic [31:0] wnext(input logic [31:0] w0, w1, w9, w14);
    return (ror(w14, 17) ^ ror(w14, 19) ^ (w14 >> 10)) + w9 +
           (ror(w1, 7) ^ ror(w1, 18) ^ (w1 >> 3)) + w0;
  endfunction

  logic [511:0] bus_data;
  logic [31:0]  hh [8];
  logic [31:0]  wv [8];
  logic [31:0]  ww [16];
  logic [255:0] dig_now;
  assign dig_now = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};

  always @(negedge clk) begin
    if (bus.init_h) for (int i = 0; i < 8; i++) hh[i] <= IV[i];
    if (bus.load_ws) begin
      for (int i = 0; i < 8; i++) wv[i] <= hh[i];
      for (int i = 0; i < 16; i++) ww[i] <= bus_data[511 - 32*i -: 32];
    end
    if (bus.round_en) begin
      wv[0] <= t1f(wv[7], wv[4], wv[5], wv[6], bus.k_out, ww[0]) + t2f(wv[0], wv[1], wv[2]);
      wv[1] <= wv[0];
      wv[2] <= wv[1];
      wv[3] <= wv[2];
      wv[4] <= wv[3] + t1f(wv[7], wv[4], wv[5], wv[6], bus.k_out, ww[0]);
      wv[5] <= wv[4];
      wv[6] <= wv[5];
      wv[7] <= wv[6];
      for (int i = 0; i < 15; i++) ww[i] <= ww[i + 1];
      ww[15] <= wnext(ww[0], ww[1], ww[9], ww[14]);
    end
    if (bus.accum) for (int i = 0; i < 8; i++) hh[i] <= hh[i] + wv[i];
  end

  // Scoreboard and round monitor.
  logic [255:0]     sb_dig [$];
  logic [CNT_W-1:0] sb_cnt [$];
  int               exp_idx = 0;
  logic             dv_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      dv_prev <= 1'b0;
    end else begin
      if (bus.load_ws) exp_idx <= 0;
      if (bus.round_en) begin
        chk("round_idx_seq", 256'(bus.round_idx), 256'(exp_idx));
        if (bus.round_idx == 6'd0)  chk("k_t0", 256'(bus.k_out), 256'(32'h428a2f98));
        if (bus.round_idx == 6'd63) chk("k_t63", 256'(bus.k_out), 256'(32'hc67178f2));
        exp_idx <= exp_idx + 1;
      end
      if (bus.accum) chk("rounds_per_block", 256'(exp_idx), 256'(64));
      if (bus.digest_valid && !dv_prev) begin
        if (sb_dig.size() == 0) begin
          chk("scoreboard_empty", 256'(1), 256'(0));
        end else begin
          chk("digest", dig_now, sb_dig.pop_front());
          chk("blk_count_done", 256'(bus.blk_count), 256'(sb_cnt.pop_front()));
        end
      end
      dv_prev <= bus.digest_valid;
    end
  end

  logic             msg_open = 1'b0;
  logic [CNT_W-1:0] tb_cnt = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait (bounded) for the transfer, and return just after it.
  task automatic send(input logic [511:0] data, input logic first, input logic last,
                      input logic [255:0] exp_dig);
    int   n;
    logic exp_init;
    n = 0;
    bus_data      = data;
    bus.blk_valid = 1'b1;
    bus.blk_first = first;
    bus.blk_last  = last;
    #1;
    while (bus.blk_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("ready_wait", 256'(n < 300), 256'(1));
    exp_init = first || !msg_open;
    chk("init_h", 256'(bus.init_h), 256'(exp_init));
    if (exp_init) tb_cnt = '0;
    tb_cnt   = tb_cnt + CNT_W'(1);
    msg_open = !last;
    if (last) begin
      sb_dig.push_back(exp_dig);
      sb_cnt.push_back(tb_cnt);
    end
    step();
    bus.blk_valid = 1'b0;
  endtask

  task automatic wait_digest();
    int n;
    n = 0;
    while (bus.digest_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("digest_wait", 256'(n < 300), 256'(1));
  endtask

  task automatic ack();
    bus.digest_ack = 1'b1;
    step();
    bus.digest_ack = 1'b0;
    tb_cnt = '0;
    #1;
    chk("ack_idle", 256'(bus.busy), 256'(0));
    chk("ack_cnt", 256'(bus.blk_count), 256'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 256'(bus.blk_ready), 256'(0));
    chk({tag, "_init"}, 256'(bus.init_h), 256'(0));
    chk({tag, "_load"}, 256'(bus.load_ws), 256'(0));
    chk({tag, "_rnd"}, 256'(bus.round_en), 256'(0));
    chk({tag, "_idx"}, 256'(bus.round_idx), 256'(0));
    chk({tag, "_k"}, 256'(bus.k_out), 256'(0));
    chk({tag, "_acc"}, 256'(bus.accum), 256'(0));
    chk({tag, "_dv"}, 256'(bus.digest_valid), 256'(0));
    chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
    chk({tag, "_cnt"}, 256'(bus.blk_count), 256'(0));
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_first = 1'b1;
    bus.blk_last = 1'b1;
    bus.digest_ack = 1'b0;
    bus_data = BLK_ABC;
    #1;
    chk_zero("rst0");
    step();
    chk_zero("rst1");
    step();
    bus.blk_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("post_reset_ready", 256'(bus.blk_ready), 256'(1));

    // Single block "abc" with cycle-exact strobe timing.
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    chk("c1_load", 256'(bus.load_ws), 256'(1));
    step();
    chk("c2_round", 256'(bus.round_en), 256'(1));
    chk("c2_idx", 256'(bus.round_idx), 256'(0));
    repeat (63) step();
    chk("c65_idx", 256'(bus.round_idx), 256'(63));
    step();
    chk("c66_accum", 256'(bus.accum), 256'(1));
    step();
    chk("c67_dv", 256'(bus.digest_valid), 256'(1));
    chk("c67_cnt", 256'(bus.blk_count), 256'(1));
    // Hold off the ack with a block waiting.
    bus.blk_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("done_no_ready", 256'(bus.blk_ready), 256'(0));
      chk("done_dv_held", 256'(bus.digest_valid), 256'(1));
    end
    bus.blk_valid = 1'b0;
    ack();

    // Two-block message.
    send(BLK_2B1, 1'b1, 1'b0, 256'(0));
    repeat (65) step();
    chk("2b_c66_ready", 256'(bus.blk_ready), 256'(0));
    step();
    chk("2b_c67_ready", 256'(bus.blk_ready), 256'(1));
    chk("2b_mid_cnt", 256'(bus.blk_count), 256'(1));
    send(BLK_2B2, 1'b0, 1'b1, DIG_2B);
    wait_digest();
    ack();

    // Enable stall at round 30.
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    repeat (31) step();
    chk("stall_pre_idx", 256'(bus.round_idx), 256'(30));
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rnd", 256'(bus.round_en), 256'(0));
      chk("stall_idx", 256'(bus.round_idx), 256'(30));
      step();
    end
    en = 1'b1;
    #1;
    chk("stall_resume_idx", 256'(bus.round_idx), 256'(30));
    chk("stall_resume_rnd", 256'(bus.round_en), 256'(1));
    wait_digest();
    ack();

    // Reset at round 40.
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    repeat (41) step();
    chk("mid_rst_idx", 256'(bus.round_idx), 256'(40));
    reset = 1'b0;
    sb_dig.delete();
    sb_cnt.delete();
    msg_open = 1'b0;
    tb_cnt = '0;
    #1;
    chk_zero("midrst");
    step();
    chk_zero("midrst_edge");
    reset = 1'b1;
    #1;
    chk("midrst_idle", 256'(bus.busy), 256'(0));
    chk("midrst_ready", 256'(bus.blk_ready), 256'(1));
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    wait_digest();
    ack();

    // Non-first block with no open message still initialises.
    send(BLK_ABC, 1'b0, 1'b1, DIG_ABC);
    wait_digest();
    ack();

    // First block arriving mid-message abandons the open message.
    send(BLK_2B1, 1'b1, 1'b0, 256'(0));
    send(BLK_ABC, 1'b1, 1'b1, DIG_ABC);
    wait_digest();
    ack();
    chk("scoreboard_drained", 256'(sb_dig.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_block_sched.md
Name: sha256_block_sched

Overview:
- Control sequencer for the SHA-256 compression datapath (the `top` hash core's round logic).
- Accepts 512-bit padded message blocks from an upstream padder through a valid/ready handshake.
- Drives the datapath through IV init, working-variable load, 64 rounds with the round constant K_t supplied, and the H accumulate step.
- Holds the final digest-valid indication until the consumer acknowledges it.
- Holds no message or hash data itself; strobes and constants only.

Parameters:
- CNT_W, 16, width of the processed-block counter (saturating).
- NUM_ROUNDS, 64, rounds per block; fixed by the standard, exposed only for reduced-round debug builds; legal range 2..64.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- en  in  1  global enable; when 0 all state/counters hold and all strobes are 0
- blk_valid  in  1  upstream has a padded block on the datapath input bus
- blk_first  in  1  qualifies blk_valid: block is first of a new message
- blk_last  in  1  qualifies blk_valid: block is last of the message
- blk_ready  out  1  controller will accept a block this cycle
- init_h  out  1  pulse: datapath loads H0..H7 with the SHA-256 IV
- load_ws  out  1  pulse: datapath loads a..h from H and W[0..15] from the block bus
- round_en  out  1  datapath performs one compression round / W shift
- round_idx  out  6  current round t, valid when round_en=1
- k_out  out  32  K_t constant for round_idx (internal 64-entry ROM)
- accum  out  1  pulse: datapath performs H_i <= H_i + working var
- digest_valid  out  1  hashed output is final; held until digest_ack
- digest_ack  in  1  consumer accepts the digest
- busy  out  1  state != IDLE
- blk_count  out  CNT_W  blocks accumulated in the current message; saturates at all-ones

Behaviour:
- States: IDLE, LOAD, ROUND, ACCUM, DONE.
- Reset (reset=0 at a rising edge), including mid-operation:
  - state goes to IDLE; round counter, blk_count and msg_active clear.
  - all outputs are 0, including blk_ready and k_out=0, for every cycle that reset is low.
- blk_ready = (state==IDLE) & en & reset. It is combinational from state.
- A transfer occurs on a cycle where blk_valid & blk_ready = 1. blk_first and blk_last are sampled only on that cycle.
- IDLE, on transfer:
  - init_h=1 in the same cycle if blk_first=1 or msg_active=0. A non-first block with no message open is treated as first.
  - blk_first=1 while a message is open abandons it: init_h=1 and blk_count restarts.
  - Latch last_q=blk_last; set msg_active=1; go to LOAD.
- LOAD: load_ws=1 for exactly one cycle; round counter <= 0; go to ROUND.
- ROUND:
  - round_en=1, round_idx = counter, k_out = K[counter].
  - counter increments each enabled cycle.
  - After the cycle with counter==NUM_ROUNDS-1, go to ACCUM.
  - Exactly NUM_ROUNDS round_en cycles per block.
- ACCUM:
  - accum=1 for one cycle; blk_count <= blk_count+1 (saturating).
  - If last_q: go to DONE and clear msg_active. Otherwise go to IDLE.
- DONE:
  - digest_valid=1 while in DONE.
  - On digest_ack=1, go to IDLE and clear blk_count. digest_ack outside DONE is ignored.
  - No new block is accepted until the ack.
- Latency with en=1: transfer at cycle 0, load_ws at 1, rounds at 2..65, accum at 66, digest_valid from 67 (last block). Next non-last block can transfer at 67.
- en=0 in any state: state, counter and latched flags freeze; all pulses 0; digest_valid stays 1 if in DONE. Resumes exactly where it left off, with no round skipped or repeated.
- K ROM: K[0]=428a2f98, K[1]=71374491, ..., K[63]=c67178f2 (FIPS 180-4).

Test Plan:
- Single block: reset low 2 cycles, then blk_valid=first=last=1 with message "abc" padded, datapath instance attached -> init_h at cycle 0, load_ws at 1, round_idx 0..63 on cycles 2..65 with k_out 428a2f98 at t=0 and c67178f2 at t=63, accum at 66, digest_valid at 67, hashed=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, blk_count=1.
- Two-block message (56-byte "abcdbcdecdefdefg..." vector) -> init_h only on block 1; blk_ready high again at cycle 67; digest_valid after second accum; blk_count=2; digest 248d6a61...19db06c1.
- en toggled low for 5 cycles at round 30 -> round_idx holds 30, round_en=0 during the stall; total round_en cycles = 64; digest unchanged vs. the no-stall run.
- Reset low at round 40 -> next cycle all outputs 0, state IDLE; next first block hashes correctly from IV.
- digest_ack held 0 for 10 cycles in DONE with blk_valid=1 -> blk_ready stays 0 and digest_valid stays 1; ack -> IDLE, blk_count=0.
- blk_first=0 with no open message -> init_h still pulses; blk_first=1 mid-message -> init_h pulses and blk_count restarts at 1 after accum.
